multdiv_issue_ctrl: RTL and testbench

//  Processor-side initiator for the iterative mult/div unit: sits in the execute stage between decode and the multdiv responder.

---
 rtl/multdiv_issue_ctrl.sv | 169 ++++++++++++++++
 tb/tb_multdiv_issue_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multdiv_issue_ctrl.sv
// Execute-stage initiator for the iterative mult/div unit. Accepts one request
// at a time, pulses the start strobe, holds the operands, stalls the pipeline
// until the result arrives or the wait budget runs out, and then presents a
// single-cycle writeback. A new request may be accepted in the writeback cycle.
module multdiv_issue_ctrl #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned REG_W   = 5,
  parameter int unsigned TIMEOUT = 40  // must be >= 2
) (
  input  logic              i_clk,
  input  logic              i_clr,
  input  logic              i_issue_valid,
  input  logic              i_issue_op,
  input  logic [DATA_W-1:0] i_issue_a,
  input  logic [DATA_W-1:0] i_issue_b,
  input  logic [REG_W-1:0]  i_issue_rd,
  output logic              o_ctrl_MULT,
  output logic              o_ctrl_DIV,
  output logic [DATA_W-1:0] o_data_operandA,
  output logic [DATA_W-1:0] o_data_operandB,
  input  logic              i_data_resultRDY,
  input  logic [DATA_W-1:0] i_data_result,
  input  logic              i_data_exception,
  output logic              o_stall,
  output logic              o_wb_valid,
  output logic [DATA_W-1:0] o_wb_data,
  output logic [REG_W-1:0]  o_wb_rd,
  output logic              o_wb_exception,
  output logic              o_busy,
  output logic              o_timeout_err
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StWait  = 2'd2,
    StDone  = 2'd3
  } state_e;

  state_e             r_state;
  state_e             w_state_d;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_d;
  logic               r_op;
  logic [DATA_W-1:0]  r_a;
  logic [DATA_W-1:0]  r_b;
  logic [REG_W-1:0]   r_rd;
  logic [DATA_W-1:0]  r_wb_data;
  logic               r_wb_exc;
  logic               r_timeout_err;
  logic               w_latch;
  logic               w_cap_rdy;
  logic               w_cap_to;

  // Next-state logic: decide transitions, request latching and result capture.
  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_latch   = 1'b0;
    w_cap_rdy = 1'b0;
    w_cap_to  = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (i_issue_valid) begin
          w_latch   = 1'b1;
          w_state_d = StStart;
        end
      end
      StStart: begin
        // A ready seen here belongs to an earlier op and is ignored.
        w_cnt_d   = '0;
        w_state_d = StWait;
      end
      StWait: begin
        w_cnt_d = r_cnt + CNT_W'(1);
        // Ready takes priority over an expiring wait budget.
        if (i_data_resultRDY) begin
          w_cap_rdy = 1'b1;
          w_state_d = StDone;
        end else if (r_cnt == CntLast) begin
          w_cap_to  = 1'b1;
          w_state_d = StDone;
        end
      end
      StDone: begin
        if (i_issue_valid) begin
          w_latch   = 1'b1;
          w_state_d = StStart;
        end else begin
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // State register and wait counter.
  always_ff @(posedge i_clk or posedge i_clr) begin
    if (i_clr) begin
      r_state <= StIdle;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
    end
  end

  // Request latch: operands stay stable from the start pulse through writeback.
  always_ff @(posedge i_clk or posedge i_clr) begin
    if (i_clr) begin
      r_op <= 1'b0;
      r_a  <= '0;
      r_b  <= '0;
      r_rd <= '0;
    end else if (w_latch) begin
      r_op <= i_issue_op;
      r_a  <= i_issue_a;
      r_b  <= i_issue_b;
      r_rd <= i_issue_rd;
    end
  end

  // Writeback capture: unit result on ready, zero with exception on timeout.
  always_ff @(posedge i_clk or posedge i_clr) begin
    if (i_clr) begin
      r_wb_data <= '0;
      r_wb_exc  <= 1'b0;
    end else if (w_cap_rdy) begin
      r_wb_data <= i_data_result;
      r_wb_exc  <= i_data_exception;
    end else if (w_cap_to) begin
      r_wb_data <= '0;
      r_wb_exc  <= 1'b1;
    end
  end

  // Sticky timeout flag, cleared only by reset.
  always_ff @(posedge i_clr or posedge i_clk) begin
    if (i_clr) begin
      r_timeout_err <= 1'b0;
    end else if (w_cap_to) begin
      r_timeout_err <= 1'b1;
    end
  end

  // Output decode from state; stall also covers a request waiting to be accepted.
  always_comb begin
    o_ctrl_MULT     = (r_state == StStart) & ~r_op;
    o_ctrl_DIV      = (r_state == StStart) & r_op;
    o_data_operandA = r_a;
    o_data_operandB = r_b;
    o_wb_valid      = (r_state == StDone);
    o_wb_data       = r_wb_data;
    o_wb_rd         = r_rd;
    o_wb_exception  = r_wb_exc;
    o_busy          = (r_state != StIdle);
    o_timeout_err   = r_timeout_err;
    o_stall         = (r_state == StStart) | (r_state == StWait) |
                      (((r_state == StIdle) | (r_state == StDone)) & i_issue_valid);
  end

  // The two start strobes are mutually exclusive.
  a_pulse_excl: assert property (@(posedge i_clk) disable iff (i_clr)
    !(o_ctrl_MULT && o_ctrl_DIV));

endmodule

// File: tb/tb_multdiv_issue_ctrl.sv
// Bench for multdiv_issue_ctrl. Plays the mult/div unit itself and predicts
// every cycle of a transaction from its issue time and the responder latency.
module tb_multdiv_issue_ctrl;

  localparam int unsigned TIMEOUT = 40;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        issue_valid = 1'b0;
  logic        issue_op = 1'b0;
  logic [31:0] issue_a = '0;
  logic [31:0] issue_b = '0;
  logic [4:0]  issue_rd = '0;
  logic        ctrl_mult;
  logic        ctrl_div;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        rdy = 1'b0;
  logic [31:0] data_result = '0;
  logic        data_exception = 1'b0;
  logic        stall;
  logic        wb_valid;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        wb_exception;
  logic        busy;
  logic        timeout_err;

  int checks = 0;
  int errors = 0;

  // Model state: current and next request, last latched operands, sticky flag.
  bit          cur_op, nx_op, nx_valid;
  logic [31:0] cur_a, cur_b, nx_a, nx_b;
  logic [4:0]  cur_rd, nx_rd;
  logic [31:0] last_a = '0;
  logic [31:0] last_b = '0;
  bit          exp_terr = 1'b0;

  multdiv_issue_ctrl #(
    .DATA_W (32),
    .REG_W  (5),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .i_clk           (clk),
    .i_clr           (clr),
    .i_issue_valid   (issue_valid),
    .i_issue_op      (issue_op),
    .i_issue_a       (issue_a),
    .i_issue_b       (issue_b),
    .i_issue_rd      (issue_rd),
    .o_ctrl_MULT     (ctrl_mult),
    .o_ctrl_DIV      (ctrl_div),
    .o_data_operandA (op_a),
    .o_data_operandB (op_b),
    .i_data_resultRDY(rdy),
    .i_data_result   (data_result),
    .i_data_exception(data_exception),
    .o_stall         (stall),
    .o_wb_valid      (wb_valid),
    .o_wb_data       (wb_data),
    .o_wb_rd         (wb_rd),
    .o_wb_exception  (wb_exception),
    .o_busy          (busy),
    .o_timeout_err   (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] unit_result(input bit op, input logic [31:0] a,
                                              input logic [31:0] b);
    if (!op) return a * b;
    if (b == 0) return 32'h0;
    return a / b;
  endfunction

  // One transaction. Cycle 0 is the issue cycle (skipped when chained onto the
  // previous writeback); the responder raises ready in wait cycle L (1-based),
  // L outside 1..TIMEOUT means never. Writeback lands in cycle 2 + waits.
  task automatic do_op(input int L, input bit exc, input bit stale, input bit chained);
    bit          to;
    int          dj;
    int          nst;
    int          npl;
    logic [31:0] res;
    to  = (L < 1) || (L > int'(TIMEOUT));
    dj  = 2 + (to ? int'(TIMEOUT) : L);
    res = unit_result(cur_op, cur_a, cur_b);
    nst = 0;
    npl = 0;
    for (int j = (chained ? 1 : 0); j <= dj; j++) begin
      @(posedge clk);
      #1;
      issue_valid = (j == 0) || (j == dj && nx_valid);
      if (j == 0) begin
        issue_op = cur_op; issue_a = cur_a; issue_b = cur_b; issue_rd = cur_rd;
      end else if (j == dj && nx_valid) begin
        issue_op = nx_op; issue_a = nx_a; issue_b = nx_b; issue_rd = nx_rd;
      end else begin
        issue_op = 1'($urandom); issue_a = $urandom; issue_b = $urandom;
        issue_rd = 5'($urandom);
      end
      rdy            = (!to && j == 1 + L) || (stale && j == 1);
      data_result    = (!to && j == 1 + L) ? res : $urandom;
      data_exception = (!to && j == 1 + L) ? exc : 1'($urandom);
      if (j == dj && to) exp_terr = 1'b1;
      @(negedge clk);
      chk("ctrl_mult", ctrl_mult, j == 1 && !cur_op);
      chk("ctrl_div", ctrl_div, j == 1 && cur_op);
      chk("stall", stall, (j < dj) || nx_valid);
      chk("busy", busy, j >= 1);
      chk("wb_valid", wb_valid, j == dj);
      chk("timeout_err", timeout_err, exp_terr);
      chk("operand_a", op_a, (j >= 1) ? cur_a : last_a);
      chk("operand_b", op_b, (j >= 1) ? cur_b : last_b);
      if (j == dj) begin
        chk("wb_data", wb_data, to ? 32'h0 : res);
        chk("wb_rd", wb_rd, cur_rd);
        chk("wb_exception", wb_exception, to ? 1'b1 : exc);
      end
      nst += int'(stall);
      npl += int'(ctrl_mult) + int'(ctrl_div);
    end
    last_a = cur_a;
    last_b = cur_b;
    chk("pulse_count", npl, 1);
    if (!chained && !nx_valid) chk("stall_cycles", nst, dj);
  endtask

  // Hard time limit; the stimulus below is bounded, so this only fires on a bench bug.
  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit chained;
    int lat;

    // Reset state.
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_stall", stall, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_pulses", {ctrl_mult, ctrl_div}, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_wb_rd", wb_rd, 0);
    chk("rst_wb_exc", wb_exception, 0);
    chk("rst_terr", timeout_err, 0);
    chk("rst_opa", op_a, 0);
    chk("rst_opb", op_b, 0);
    @(negedge clk);
    clr = 1'b0;
    nx_valid = 1'b0;

    // Multiply 7*6 with the result 17 wait cycles later.
    cur_op = 1'b0; cur_a = 32'd7; cur_b = 32'd6; cur_rd = 5'd9;
    do_op(17, 1'b0, 1'b0, 1'b0);

    // Divide by zero: unit flags an exception together with ready.
    cur_op = 1'b1; cur_a = 32'd100; cur_b = 32'd0; cur_rd = 5'd3;
    do_op(5, 1'b1, 1'b0, 1'b0);

    // Responder never answers: timeout writeback, sticky flag.
    cur_op = 1'b0; cur_a = 32'h1234; cur_b = 32'h55; cur_rd = 5'd17;
    do_op(0, 1'b0, 1'b0, 1'b0);

    // Stale ready in the start cycle, real ready on the last allowed wait cycle.
    cur_op = 1'b1; cur_a = 32'd1000; cur_b = 32'd7; cur_rd = 5'd31;
    do_op(int'(TIMEOUT), 1'b0, 1'b1, 1'b0);

    // Back-to-back: second request offered during the first writeback.
    cur_op = 1'b0; cur_a = 32'hdead; cur_b = 32'h11; cur_rd = 5'd1;
    nx_op = 1'b1; nx_a = 32'hbeef0000; nx_b = 32'd3; nx_rd = 5'd2; nx_valid = 1'b1;
    do_op(3, 1'b0, 1'b0, 1'b0);
    cur_op = nx_op; cur_a = nx_a; cur_b = nx_b; cur_rd = nx_rd; nx_valid = 1'b0;
    do_op(1, 1'b0, 1'b0, 1'b1);

    // Reset in the middle of a wait: everything drops at once, no writeback.
    @(posedge clk); #1;
    issue_valid = 1'b1; issue_op = 1'b0; issue_a = 32'd123; issue_b = 32'd456;
    issue_rd = 5'd4;
    @(posedge clk); #1;
    issue_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    clr = 1'b1;
    #1;
    exp_terr = 1'b0;
    last_a = '0;
    last_b = '0;
    chk("clr_busy", busy, 0);
    chk("clr_stall", stall, 0);
    chk("clr_wb_valid", wb_valid, 0);
    chk("clr_pulses", {ctrl_mult, ctrl_div}, 0);
    chk("clr_terr", timeout_err, 0);
    chk("clr_opa", op_a, 0);
    chk("clr_wb_data", wb_data, 0);
    @(negedge clk);
    clr = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      rdy = 1'b1; data_result = $urandom;
      @(negedge clk);
      chk("post_clr_wb_valid", wb_valid, 0);
      chk("post_clr_busy", busy, 0);
    end
    rdy = 1'b0;
    cur_op = 1'b0; cur_a = 32'd12; cur_b = 32'd12; cur_rd = 5'd12;
    do_op(2, 1'b0, 1'b0, 1'b0);

    // Randomized transactions, some chained, some timing out.
    chained = 1'b0;
    for (int k = 0; k < 25; k++) begin
      if (!chained) begin
        cur_op = 1'($urandom); cur_a = $urandom; cur_b = $urandom_range(0, 50);
        cur_rd = 5'($urandom);
      end
      nx_op = 1'($urandom); nx_a = $urandom; nx_b = $urandom_range(0, 50);
      nx_rd = 5'($urandom);
      nx_valid = (k < 24) && ($urandom_range(0, 2) == 0);
      lat = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, TIMEOUT));
      do_op(lat, 1'($urandom), 1'($urandom), chained);
      chained = nx_valid;
      if (chained) begin
        cur_op = nx_op; cur_a = nx_a; cur_b = nx_b; cur_rd = nx_rd;
      end
    end
    nx_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
